// File: rtl/mc_pkg.sv
// Shared types and defaults for the multicycle memory responder.
//   word_t        : 32-bit memory word
//   resp_state_e  : responder FSM state (IDLE, WAIT, RESP)
//   mem_req_t     : request captured at acceptance
package mc_pkg;

    localparam int unsigned DEF_DEPTH_WORDS = 1024;
    localparam int unsigned DEF_LATENCY     = 2;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned STRB_W          = WORD_W / 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_e;

    typedef struct packed {
        logic              rd;
        logic              wr;
        word_t             addr;
        word_t             wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/mc_mem_array.sv
// Word-organised storage for the responder. No reset on the contents.
//   clk     : write clock
//   we      : write enable (one word per cycle)
//   wstrb   : byte-lane enables for the write
//   waddr   : word index written
//   wdata   : write data
//   raddr   : word index read
//   rdata_c : combinational read of word raddr
module mc_mem_array
    import mc_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [3:0]                     wstrb,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [31:0]                    wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [31:0]                    rdata_c
);

    word_t mem [DEPTH_WORDS];

    // Byte-masked write
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/mc_mem_responder.sv
// Fixed-latency memory responder for a multicycle CPU control path.
// A request is accepted in IDLE, completes LATENCY cycles later with a
// one-cycle ready pulse; fault flags requests that performed no access.
// Optional build macro: MC_MEM_ALIGN_CHECK_EN (fault on addr[1:0] != 0).
//   clk, rst           : clock, asynchronous active-low reset
//   mem_read/mem_write : request type, held by the requester until ready
//   addr, wdata, wstrb : byte address, store data, byte-lane enables
//   rdata              : read data, held until the next read completes
//   ready, busy, fault : completion pulse, in-flight flag, no-access flag
module mc_mem_responder
    import mc_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned LATENCY     = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        fault
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    resp_state_e   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    mem_req_t      req_q, req_d;
    mem_req_t      cur_c;
    logic          fault_c;
    logic          resp_entry_c;
    logic          commit_c;
    logic [AW-1:0] widx_c;
    word_t         mem_rdata_c;

    // With LATENCY=1 the access happens on the accept edge, so the live
    // inputs are used in IDLE and the captured request afterwards.
    always_comb begin
        cur_c = req_q;
        if (state_q == ST_IDLE) begin
            cur_c.rd    = mem_read;
            cur_c.wr    = mem_write;
            cur_c.addr  = addr;
            cur_c.wdata = wdata;
            cur_c.wstrb = wstrb;
        end
    end

    // No-access conditions: conflicting type, or address beyond the array
    always_comb begin
        fault_c = (cur_c.rd && cur_c.wr) || ((cur_c.addr >> (AW + 2)) != 32'd0);
`ifdef MC_MEM_ALIGN_CHECK_EN
        fault_c = fault_c || (cur_c.addr[1:0] != 2'b00);
`endif
    end

`ifndef MC_MEM_ALIGN_CHECK_EN
    // Byte offset is dropped when alignment is not checked
    logic unused_lsb_c;
    assign unused_lsb_c = ^cur_c.addr[1:0];
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    req_d = cur_c;
                    if (LATENCY > 1) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(LATENCY - 2);
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        resp_entry_c = (state_d == ST_RESP) && (state_q != ST_RESP);
        commit_c     = resp_entry_c && cur_c.wr && !fault_c;
    end

    assign widx_c = cur_c.addr[AW+1:2];

    mc_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .we      (commit_c),
        .wstrb   (cur_c.wstrb),
        .waddr   (widx_c),
        .wdata   (cur_c.wdata),
        .raddr   (widx_c),
        .rdata_c (mem_rdata_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ready   <= (state_d == ST_RESP);
            busy    <= (state_d != ST_IDLE);
            fault   <= (state_d == ST_RESP) && fault_c;
            // Only a pure read updates rdata; a faulted read returns zero
            if (resp_entry_c && cur_c.rd && !cur_c.wr) begin
                rdata <= fault_c ? 32'd0 : mem_rdata_c;
            end
        end
    end

endmodule

// File: tb/tb_mc_mem_responder.sv
// Scoreboard bench for mc_mem_responder: three instances with LATENCY 2, 1, 4.
module tb_mc_mem_responder;
    import mc_pkg::*;

    localparam int NDUT = 3;

    logic        clk;
    logic        rst_n;
    logic        rd_v    [NDUT];
    logic        wr_v    [NDUT];
    logic [31:0] addr_v  [NDUT];
    logic [31:0] wdata_v [NDUT];
    logic [3:0]  wstrb_v [NDUT];
    logic [31:0] rdata_v [NDUT];
    logic        ready_v [NDUT];
    logic        busy_v  [NDUT];
    logic        fault_v [NDUT];

    int vectors;
    int miscompares;

    typedef struct {
        word_t rdata;
        logic  chk;
        logic  fault;
        int    lat;
    } exp_t;

    typedef struct {
        logic       rd;
        logic       wr;
        word_t      addr;
        word_t      wdata;
        logic [3:0] wstrb;
        word_t      rdata;
        logic       chk;
        logic       fault;
    } txn_t;

    exp_t sb[$];

    mc_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst_n), .mem_read(rd_v[0]), .mem_write(wr_v[0]),
        .addr(addr_v[0]), .wdata(wdata_v[0]), .wstrb(wstrb_v[0]),
        .rdata(rdata_v[0]), .ready(ready_v[0]), .busy(busy_v[0]), .fault(fault_v[0]));

    mc_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst_n), .mem_read(rd_v[1]), .mem_write(wr_v[1]),
        .addr(addr_v[1]), .wdata(wdata_v[1]), .wstrb(wstrb_v[1]),
        .rdata(rdata_v[1]), .ready(ready_v[1]), .busy(busy_v[1]), .fault(fault_v[1]));

    mc_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut2 (
        .clk(clk), .rst(rst_n), .mem_read(rd_v[2]), .mem_write(wr_v[2]),
        .addr(addr_v[2]), .wdata(wdata_v[2]), .wstrb(wstrb_v[2]),
        .rdata(rdata_v[2]), .ready(ready_v[2]), .busy(busy_v[2]), .fault(fault_v[2]));

    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        case (d)
            0: return 2;
            1: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic txn_t mk(input logic rd, input logic wr, input word_t a, input word_t wd,
                                input logic [3:0] ws, input word_t rdx, input logic chk, input logic f);
        txn_t t;
        t.rd = rd; t.wr = wr; t.addr = a; t.wdata = wd; t.wstrb = ws;
        t.rdata = rdx; t.chk = chk; t.fault = f;
        return t;
    endfunction

    // Called at a negedge with the DUT idle; drives a request, holds it until
    // ready, and returns at a negedge with the DUT idle again.
    task automatic run_req(input int d, input logic rd, input logic wr, input word_t a,
                           input word_t wd, input logic [3:0] ws,
                           output int lat, output int busy_cnt, output word_t rdo, output logic flo);
        int   cyc;
        logic got;
        rd_v[d] = rd; wr_v[d] = wr; addr_v[d] = a; wdata_v[d] = wd; wstrb_v[d] = ws;
        cyc = 0; got = 1'b0; busy_cnt = 0; rdo = '0; flo = 1'b0;
        while (!got && cyc < 32) begin
            @(negedge clk);
            cyc++;
            if (busy_v[d] === 1'b1) busy_cnt++;
            if (ready_v[d] === 1'b1) begin
                got = 1'b1;
                rdo = rdata_v[d];
                flo = fault_v[d];
            end
        end
        rd_v[d] = 1'b0; wr_v[d] = 1'b0;
        lat = got ? cyc : -1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            vectors++; if (ready_v[d] !== 1'b0) begin miscompares++; $display("FAIL reset_ready[%0d]: got %b want 0", d, ready_v[d]); end
            vectors++; if (busy_v[d] !== 1'b0) begin miscompares++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy_v[d]); end
            vectors++; if (fault_v[d] !== 1'b0) begin miscompares++; $display("FAIL reset_fault[%0d]: got %b want 0", d, fault_v[d]); end
            vectors++; if (rdata_v[d] !== 32'h0) begin miscompares++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, rdata_v[d]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_functional();
        txn_t  t[$];
        exp_t  e;
        int    lat, bc;
        word_t rdo;
        logic  flo;
        t.push_back(mk(1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1'b0));
        t.push_back(mk(1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b1, 1'b0));
        t.push_back(mk(1'b0, 1'b1, 32'h20,       32'hFFFFFFFF, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0));
        t.push_back(mk(1'b0, 1'b1, 32'h20,       32'h11223344, 4'h5, 32'h0,        1'b0, 1'b0));
        t.push_back(mk(1'b1, 1'b0, 32'h20,       32'h0,        4'h0, 32'hFF22FF44, 1'b1, 1'b0));
        t.push_back(mk(1'b0, 1'b1, 32'h20,       32'hAABBCCDD, 4'h0, 32'h0,        1'b0, 1'b0));
        t.push_back(mk(1'b1, 1'b0, 32'h20,       32'h0,        4'h0, 32'hFF22FF44, 1'b1, 1'b0));
        t.push_back(mk(1'b0, 1'b1, 32'h00,       32'h0BADF00D, 4'hF, 32'h0,        1'b0, 1'b0));
        t.push_back(mk(1'b1, 1'b1, 32'h00,       32'h12345678, 4'hF, 32'h0,        1'b0, 1'b1));
        t.push_back(mk(1'b1, 1'b0, 32'h00,       32'h0,        4'h0, 32'h0BADF00D, 1'b1, 1'b0));
        t.push_back(mk(1'b1, 1'b0, 32'h1000,     32'h0,        4'h0, 32'h0,        1'b1, 1'b1));
        t.push_back(mk(1'b0, 1'b1, 32'h1000,     32'hCAFEBABE, 4'hF, 32'h0,        1'b1, 1'b1));
        t.push_back(mk(1'b1, 1'b0, 32'h00,       32'h0,        4'h0, 32'h0BADF00D, 1'b1, 1'b0));
`ifdef MC_MEM_ALIGN_CHECK_EN
        t.push_back(mk(1'b1, 1'b0, 32'h12,       32'h0,        4'h0, 32'h0,        1'b1, 1'b1));
`else
        t.push_back(mk(1'b1, 1'b0, 32'h12,       32'h0,        4'h0, 32'hDEADBEEF, 1'b1, 1'b0));
`endif
        t.push_back(mk(1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1, 1'b1));
        t.push_back(mk(1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b1, 1'b0));
        t.push_back(mk(1'b0, 1'b1, 32'h40,       32'h01020304, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0));
        t.push_back(mk(1'b0, 1'b1, 32'hFFC,      32'h76543210, 4'hF, 32'h0,        1'b0, 1'b0));
        t.push_back(mk(1'b1, 1'b0, 32'hFFC,      32'h0,        4'h0, 32'h76543210, 1'b1, 1'b0));
        foreach (t[i]) begin
            e.rdata = t[i].rdata; e.chk = t[i].chk; e.fault = t[i].fault; e.lat = 2;
            sb.push_back(e);
            run_req(0, t[i].rd, t[i].wr, t[i].addr, t[i].wdata, t[i].wstrb, lat, bc, rdo, flo);
            e = sb.pop_front();
            vectors++; if (lat !== e.lat) begin miscompares++; $display("FAIL func[%0d] latency: got %0d want %0d", i, lat, e.lat); end
            vectors++; if (bc !== e.lat) begin miscompares++; $display("FAIL func[%0d] busy_cycles: got %0d want %0d", i, bc, e.lat); end
            vectors++; if (flo !== e.fault) begin miscompares++; $display("FAIL func[%0d] fault: got %b want %b", i, flo, e.fault); end
            if (e.chk) begin
                vectors++; if (rdo !== e.rdata) begin miscompares++; $display("FAIL func[%0d] rdata: got %h want %h", i, rdo, e.rdata); end
            end
        end
    endtask

    task automatic test_reset_wait();
        exp_t  e;
        int    lat, bc;
        word_t rdo;
        logic  flo;
        run_req(0, 1'b0, 1'b1, 32'h30, 32'h55AA55AA, 4'hF, lat, bc, rdo, flo);
        vectors++; if (flo !== 1'b0) begin miscompares++; $display("FAIL rstwait_prewrite fault: got %b want 0", flo); end
        e.rdata = 32'h55AA55AA; e.chk = 1'b1; e.fault = 1'b0; e.lat = 2;
        sb.push_back(e);
        run_req(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, lat, bc, rdo, flo);
        e = sb.pop_front();
        vectors++; if (rdo !== e.rdata) begin miscompares++; $display("FAIL rstwait_preread rdata: got %h want %h", rdo, e.rdata); end
        // Start a write, then reset while it is waiting
        rd_v[0] = 1'b0; wr_v[0] = 1'b1; addr_v[0] = 32'h30; wdata_v[0] = 32'h12345678; wstrb_v[0] = 4'hF;
        @(negedge clk);
        vectors++; if (busy_v[0] !== 1'b1) begin miscompares++; $display("FAIL rstwait_busy_before: got %b want 1", busy_v[0]); end
        rst_n = 1'b0;
        #1;
        vectors++; if (ready_v[0] !== 1'b0) begin miscompares++; $display("FAIL rstwait_ready: got %b want 0", ready_v[0]); end
        vectors++; if (busy_v[0] !== 1'b0) begin miscompares++; $display("FAIL rstwait_busy: got %b want 0", busy_v[0]); end
        vectors++; if (fault_v[0] !== 1'b0) begin miscompares++; $display("FAIL rstwait_fault: got %b want 0", fault_v[0]); end
        vectors++; if (rdata_v[0] !== 32'h0) begin miscompares++; $display("FAIL rstwait_rdata: got %h want 0", rdata_v[0]); end
        wr_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // Request presented at deassertion is accepted on the very next edge
        e.rdata = 32'h55AA55AA; e.chk = 1'b1; e.fault = 1'b0; e.lat = 2;
        sb.push_back(e);
        run_req(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, lat, bc, rdo, flo);
        e = sb.pop_front();
        vectors++; if (lat !== e.lat) begin miscompares++; $display("FAIL rstwait_post latency: got %0d want %0d", lat, e.lat); end
        vectors++; if (rdo !== e.rdata) begin miscompares++; $display("FAIL rstwait_post rdata: got %h want %h", rdo, e.rdata); end
    endtask

    task automatic test_latency();
        exp_t  e;
        int    lat, bc;
        word_t rdo;
        logic  flo;
        for (int d = 1; d < NDUT; d++) begin
            run_req(d, 1'b0, 1'b1, 32'h80, 32'hA5A50000 + 32'(d), 4'hF, lat, bc, rdo, flo);
            vectors++; if (lat !== lat_of(d)) begin miscompares++; $display("FAIL lat[%0d] write latency: got %0d want %0d", d, lat, lat_of(d)); end
            e.rdata = 32'hA5A50000 + 32'(d); e.chk = 1'b1; e.fault = 1'b0; e.lat = lat_of(d);
            sb.push_back(e);
            run_req(d, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, lat, bc, rdo, flo);
            e = sb.pop_front();
            vectors++; if (lat !== e.lat) begin miscompares++; $display("FAIL lat[%0d] read latency: got %0d want %0d", d, lat, e.lat); end
            vectors++; if (bc !== e.lat) begin miscompares++; $display("FAIL lat[%0d] busy_cycles: got %0d want %0d", d, bc, e.lat); end
            vectors++; if (flo !== e.fault) begin miscompares++; $display("FAIL lat[%0d] fault: got %b want %b", d, flo, e.fault); end
            vectors++; if (rdo !== e.rdata) begin miscompares++; $display("FAIL lat[%0d] rdata: got %h want %h", d, rdo, e.rdata); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t  e;
        int    lat, bc;
        word_t rdo;
        logic  flo;
        logic  exp_rdy;
        run_req(1, 1'b0, 1'b1, 32'h10, 32'h13579BDF, 4'hF, lat, bc, rdo, flo);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL b2b_write latency: got %0d want 1", lat); end
        // Read held high: accept, RESP (not sampled), accept, ...
        rd_v[1] = 1'b1; wr_v[1] = 1'b0; addr_v[1] = 32'h10;
        for (int k = 0; k < 4; k++) begin
            e.rdata = 32'h13579BDF; e.chk = 1'b1; e.fault = 1'b0; e.lat = 1;
            sb.push_back(e);
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_rdy = ((i % 2) == 1);
            vectors++; if (ready_v[1] !== exp_rdy) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, ready_v[1], exp_rdy); end
            vectors++; if (busy_v[1] !== exp_rdy) begin miscompares++; $display("FAIL b2b_busy[%0d]: got %b want %b", i, busy_v[1], exp_rdy); end
            if (ready_v[1] === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL b2b_extra_ready[%0d]: got pulse want none", i);
                end else begin
                    e = sb.pop_front();
                    vectors++; if (rdata_v[1] !== e.rdata) begin miscompares++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rdata_v[1], e.rdata); end
                end
            end
        end
        rd_v[1] = 1'b0;
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL b2b_pending: got %0d outstanding want 0", sb.size()); end
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        vectors = 0;
        miscompares = 0;
        for (int d = 0; d < NDUT; d++) begin
            rd_v[d] = 1'b0; wr_v[d] = 1'b0; addr_v[d] = '0; wdata_v[d] = '0; wstrb_v[d] = '0;
        end
        test_reset();
        test_functional();
        test_reset_wait();
        test_latency();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_mem_responder.md
MC_MEM_RESPONDER -- requirements
Module: mc_mem_responder

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the unified instruction/data memory (power of two).
REQ-002 SHALL provide parameter LATENCY, default 2, meaning the number of cycles from request acceptance to ready; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous assert, active-low.
REQ-005 mem_read  input  1  read request from the multicycle control path.
REQ-006 mem_write  input  1  write request from the multicycle control path.
REQ-007 addr  input  32  byte address, already muxed by IorD upstream.
REQ-008 wdata  input  32  store data.
REQ-009 wstrb  input  4  byte-lane write enables; bit n selects wdata[8n+7:8n].
REQ-010 rdata  output  32  read data; valid when ready=1 for a read.
REQ-011 ready  output  1  one-cycle completion pulse for every accepted request.
REQ-012 busy  output  1  high from acceptance until the cycle ready is asserted, inclusive.
REQ-013 fault  output  1  qualifies ready; high when the completed request performed no access.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 IDLE: if mem_read or mem_write is high, latch addr, wdata, wstrb and the request type, then go to WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-016 WAIT: load a counter with LATENCY-2 on entry, decrement each cycle, and go to RESP when it reaches 0.
REQ-017 RESP: assert ready for exactly one cycle, then return to IDLE; a new request is sampled on the following cycle, never in RESP.
REQ-018 Requests present while busy=1 SHALL be ignored; requesters hold their signals until ready.
REQ-019 A write SHALL commit only the wstrb-enabled bytes to word addr[log2(DEPTH_WORDS)+1:2], on the edge entering RESP.
REQ-020 For a read, rdata SHALL carry the addressed word during RESP and hold it until the next read completes; writes SHALL NOT change rdata.
REQ-021 If mem_read and mem_write are both high at acceptance, the block SHALL do no access and complete after LATENCY cycles with fault=1.
REQ-022 If addr >= 4*DEPTH_WORDS, the block SHALL do no access and complete after LATENCY cycles with fault=1; for a read, rdata SHALL be 0.
REQ-023 A write with wstrb=0 SHALL complete normally (fault=0) and change no memory.
REQ-024 Accept-to-ready latency SHALL be exactly LATENCY cycles: accept on edge k, ready high during cycle k+LATENCY.

Reset
REQ-025 Assertion of rst SHALL immediately force state IDLE and counter 0, with ready=0, busy=0, fault=0 and rdata=0.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 A reset during WAIT SHALL abort the request, and a pending write SHALL NOT be committed.
REQ-028 Deassertion SHALL be synchronized externally; the first request can be accepted on the first edge after deassertion.

Configuration
REQ-029 Macro MC_MEM_ALIGN_CHECK_EN, when defined: a request with addr[1:0]!=0 SHALL do no access and complete with fault=1 after LATENCY cycles.
REQ-030 Macro MC_MEM_ALIGN_CHECK_EN, when undefined: addr[1:0] SHALL be ignored, and such a request SHALL access the word at addr with bits 1:0 cleared.

Structure
REQ-031 Shared package mc_pkg SHALL hold the responder state enum, the default DEPTH_WORDS and LATENCY constants, and the 32-bit word typedef.
REQ-032 The storage SHALL be a sub-module mc_mem_array: a synchronous byte-masked write, a read port, no reset.

Verification
REQ-033 Reset, then read 0x0000_0010 after preloading 0xDEAD_BEEF -> busy for 2 cycles, ready pulse at accept+2, rdata=0xDEADBEEF, fault=0.
REQ-034 Write 0x0000_0020, wdata=0x1122_3344, wstrb=4'b0101 over 0xFFFF_FFFF, then read 0x20 -> rdata=0xFF22FF44.
REQ-035 mem_read=mem_write=1 at 0x0 -> ready at accept+2 with fault=1, and memory at 0x0 unchanged.
REQ-036 Read 0x0000_1000 with DEPTH_WORDS=1024 -> fault=1, rdata=0; read 0x0000_0012 -> fault=1 with macro, word 0x10 returned without it.
REQ-037 Write 0x0000_0030 then assert rst during WAIT -> outputs 0 immediately, and a later read of 0x30 returns the old value.
REQ-038 LATENCY=1: back-to-back reads held high -> ready every second cycle, and no request is accepted during RESP.
